// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with hardwired zero register at top index, pending-write scoreboard, optional forwarding (REGFILE_SB_BYPASS_EN)
module regfile_sb #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    RegWrite,
  input  logic [ADDR_W-1:0]       WriteRegister,
  input  logic [DATA_W-1:0]       WriteData,
  input  logic [NREAD*ADDR_W-1:0] ReadRegister,
  output logic [NREAD*DATA_W-1:0] ReadData,
  input  logic                    IssueValid,
  input  logic [ADDR_W-1:0]       IssueRegister,
  input  logic                    Flush,
  output logic [NREAD-1:0]        Busy
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZR = '1;
  logic [DATA_W-1:0] r_mem [NREG-1];
  logic [NREG-2:0]   r_busy;
  logic [NREG-1:0]   w_busy;
  assign w_busy = {1'b0, r_busy};
  // data storage: reset clears every entry, writes to the zero register have no target
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG-1; i++)
      if (!reset) r_mem[i] <= '0;
      else if (RegWrite && WriteRegister == ADDR_W'(i)) r_mem[i] <= WriteData;
  end
  // scoreboard: flush beats issue, issue beats writeback clear of the same index
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG-1; i++)
      if (!reset || Flush) r_busy[i] <= 1'b0;
      else if (IssueValid && IssueRegister == ADDR_W'(i)) r_busy[i] <= 1'b1;
      else if (RegWrite && WriteRegister == ADDR_W'(i)) r_busy[i] <= 1'b0;
  end
  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_zero;
    assign w_ra   = ReadRegister[p*ADDR_W +: ADDR_W];
    assign w_zero = w_ra == ZR;
`ifdef REGFILE_SB_BYPASS_EN
    logic w_hit;
    assign w_hit = RegWrite && WriteRegister == w_ra && !w_zero;
    assign ReadData[p*DATA_W +: DATA_W] = w_zero ? '0 : w_hit ? WriteData : r_mem[w_ra];
    assign Busy[p] = w_busy[w_ra] && !(w_hit && !(IssueValid && IssueRegister == w_ra));
`else
    assign ReadData[p*DATA_W +: DATA_W] = w_zero ? '0 : r_mem[w_ra];
    assign Busy[p] = w_busy[w_ra];
`endif
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file for the pipelined core, generalising the fixed 32×64, two-read-port file. It has a configurable data width, address width and read-port count, and a hardwired zero register at the top index. It adds a synchronous clear and a per-register pending-write scoreboard, which decode uses for hazard detection. Optional write-to-read forwarding is available. It sits between decode (reads, issue) and writeback (writes).

## Interface
Parameters:
- DATA_W, 64, register width in bits.
- ADDR_W, 5, register index width. The file holds NREG = 2^ADDR_W entries, and index NREG-1 is the zero register.
- NREAD, 2, number of read ports (≥1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- RegWrite  input  1  write enable from writeback.
- WriteRegister  input  ADDR_W  write index.
- WriteData  input  DATA_W  write data.
- ReadRegister  input  NREAD×ADDR_W  read index per port; port p uses slice p.
- ReadData  output  NREAD×DATA_W  read data per port.
- IssueValid  input  1  an instruction that writes IssueRegister is issuing this cycle.
- IssueRegister  input  ADDR_W  destination of the issuing instruction.
- Flush  input  1  clears all pending-write bits (pipeline squash).
- Busy  output  NREAD  per read port: the addressed register has an outstanding write.

## Operation
- Storage: NREG-1 physical registers of DATA_W bits. Index NREG-1 has no storage.
- Reads are combinational per port. Reading index NREG-1 always returns 0.
- Write: on the rising edge with reset=1, RegWrite=1 and WriteRegister≠NREG-1, the entry is loaded with WriteData.
  - A write to NREG-1 is discarded.
- Scoreboard: one busy bit per index. The bit for NREG-1 is constant 0.
  - Clear: RegWrite=1 with WriteRegister=r clears busy[r].
  - Set: IssueValid=1 with IssueRegister=r sets busy[r] (r≠NREG-1).
- Scoreboard priority per edge, highest first:
  - reset=0: all busy bits 0.
  - Flush=1: all busy bits 0; the issue in that cycle is ignored, and writes still update data.
  - Set by issue wins over clear by write when both target the same r in one cycle, because a newer producer is outstanding.
  - Clear by write applies otherwise.
- Busy[p] = busy[ReadRegister[p]], subject to the bypass rule in Configuration.
- Reset: while reset=0 at an edge, all data entries load 0 and all busy bits load 0. Reset overrides RegWrite, IssueValid and Flush in that cycle.
- Reset asserted mid-operation discards any in-flight write on that edge.

## Timing
- Read latency 0 cycles, combinational from ReadRegister and current state.
- Write latency: data is visible on ReadData in the cycle after the write edge. This is 0 cycles if forwarding is compiled in.
- Busy set or clear is visible in the cycle after the edge. The same-cycle exception is the bypass case in Configuration.
- Reset values of outputs after the first reset edge:
  - ReadData = 0 for every index.
  - Busy = 0.
- Asynchronous reset behaviour is not permitted. Before the first reset edge, state is undefined.
- Multiple read ports addressing the same index return identical data and Busy.

## Configuration
- Macro `REGFILE_SB_BYPASS_EN`.
- Defined:
  - When RegWrite=1, WriteRegister=ReadRegister[p] and ReadRegister[p]≠NREG-1, then ReadData[p]=WriteData in the same cycle.
  - Busy[p] is forced to 0 in that cycle, since the value is available, unless IssueValid=1 with IssueRegister equal to the same index.
- Undefined:
  - Read-during-write returns the old stored value.
  - Busy[p] reflects the registered bit only, so it stays 1 during the writeback cycle.

## Test plan
- Reset clear: write 0xDEAD_BEEF to x3, then hold reset=0 for one edge. Response: every index reads 0 and Busy=0.
- Zero register: RegWrite=1, WriteRegister=31, WriteData=0x1234, IssueValid=1, IssueRegister=31 (defaults). Response: index 31 reads 0 and Busy stays 0 on every port.
- Read-during-write on x7 with old value 0x5 and new value 0xA.
  - With the macro: same cycle ReadData=0xA.
  - Without the macro: same cycle ReadData=0x5; next cycle 0xA.
- Scoreboard: issue x4, wait 2 cycles (Busy=1), then write x4.
  - With the macro: Busy=0 in the write cycle.
  - Without the macro: Busy is 1 in the write cycle and 0 on the next.
- Simultaneous issue and write of x9: Busy=1 after the edge. A second issue of x9 plus Flush in the same cycle gives Busy=0 after the edge.
- Parameter sweep DATA_W=32, ADDR_W=4, NREAD=3: 15 writable registers plus a zero register at index 15. Three ports read distinct and then identical indices correctly.
